minsoc_clock_monitor: RTL and testbench



---
 rtl/minsoc_clock_monitor.sv | 196 +++++++++++++++++++
 tb/tb_minsoc_clock_monitor.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minsoc_clock_monitor.sv
// ---------------------------------------------------------------------------
// minsoc_clock_monitor
//
// Watches the divided system clock from the SoC clock manager. The divided
// clock is treated as plain data: it passes through a 2-flop synchronizer on
// the undivided reference clock, and its rising edges are timestamped with a
// saturating cycle counter. Each measured period is compared with DIVISOR
// (+/- TOLERANCE). LOCK_COUNT consecutive good periods give lock. A bad
// period or a stall while locked raises a sticky fault that only clear_i
// removes.
//
// Ports:
//   clk_i         reference clock, all logic on its rising edge
//   rst_n_i       synchronous reset, active-low
//   clk_div_i     divided clock under test (asynchronous, data only)
//   clear_i       one-cycle pulse: clear fault, restart acquisition
//   edge_o        one-cycle pulse per detected rising edge of clk_div_i
//   period_o      last measured period in clk_i cycles (saturating)
//   locked_o      high while in LOCKED
//   fault_o       sticky fault flag
//   fault_code_o  00 none, 01 bad period, 10 stall
// ---------------------------------------------------------------------------
module minsoc_clock_monitor #(
    parameter int unsigned DIVISOR    = 4,
    parameter int unsigned TOLERANCE  = 1,
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clk_div_i,
    input  logic        clear_i,
    output logic        edge_o,
    output logic [15:0] period_o,
    output logic        locked_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        FAULT   = 2'd2
    } state_e;

    localparam logic [16:0] DivisorWide   = 17'(DIVISOR);
    localparam logic [16:0] ToleranceWide = 17'(TOLERANCE);
    localparam logic [15:0] StallCount    = 16'(TIMEOUT - 1);
    localparam logic [7:0]  LockTarget    = 8'(LOCK_COUNT);
    localparam logic [1:0]  CodeNone      = 2'b00;
    localparam logic [1:0]  CodeBadPeriod = 2'b01;
    localparam logic [1:0]  CodeStall     = 2'b10;

    logic        sync1_q, sync2_q, prev_q;
    logic        edge_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period_q, period_d;
    logic        haveEdge_q, haveEdge_d;
    logic [7:0]  goodCnt_q, goodCnt_d;
    logic [1:0]  faultCode_q, faultCode_d;
    state_e      state_q, state_d;

    logic        edgeDet;
    logic        measEdge;
    logic        stall;
    logic        goodPeriod;
    logic [15:0] meas;
    logic [16:0] measWide;
    logic [16:0] absDelta;

    // Rising edge of the synchronized divided clock, and the period it closes.
    // The counter was zeroed in the cycle after the previous edge, so the
    // period is the count plus one (held at all-ones once saturated).
    // The deviation is taken in 17 bits so that a saturated measurement
    // cannot wrap around into the good window.
    always_comb begin
        edgeDet    = sync2_q & ~prev_q;
        measEdge   = edgeDet & haveEdge_q;
        meas       = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;
        measWide   = {1'b0, meas};
        absDelta   = (measWide >= DivisorWide) ? (measWide - DivisorWide)
                                               : (DivisorWide - measWide);
        goodPeriod = (absDelta <= ToleranceWide);
        stall      = (cnt_q == StallCount) && !edgeDet;
    end

    // Free-running saturating cycle counter, restarted by every edge. Because
    // it keeps counting past the stall threshold, a stall fires only once in
    // any single gap.
    always_comb begin
        cnt_d = cnt_q;
        if (edgeDet) begin
            cnt_d = 16'd0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Next-state logic for acquisition, lock and fault. clear_i overrides any
    // coincident edge or stall; an edge that arrives with the clear only arms
    // the measurement (it becomes the new first edge). Faults are recorded
    // only from LOCKED; during acquisition, bad periods and stalls simply
    // restart the good-period count.
    always_comb begin
        state_d     = state_q;
        goodCnt_d   = goodCnt_q;
        haveEdge_d  = haveEdge_q;
        faultCode_d = faultCode_q;
        period_d    = period_q;

        if (clear_i) begin
            state_d     = ACQUIRE;
            goodCnt_d   = 8'd0;
            faultCode_d = CodeNone;
            haveEdge_d  = edgeDet;
        end else begin
            if (edgeDet) begin
                haveEdge_d = 1'b1;
            end else if (stall) begin
                haveEdge_d = 1'b0;
            end

            if (measEdge) begin
                period_d = meas;
            end

            case (state_q)
                ACQUIRE: begin
                    if (measEdge && goodPeriod) begin
                        if (goodCnt_q + 8'd1 >= LockTarget) begin
                            state_d   = LOCKED;
                            goodCnt_d = LockTarget;
                        end else begin
                            goodCnt_d = goodCnt_q + 8'd1;
                        end
                    end else if ((measEdge && !goodPeriod) || stall) begin
                        goodCnt_d = 8'd0;
                    end
                end
                LOCKED: begin
                    if (measEdge && !goodPeriod) begin
                        state_d     = FAULT;
                        faultCode_d = CodeBadPeriod;
                    end else if (stall) begin
                        state_d     = FAULT;
                        faultCode_d = CodeStall;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = ACQUIRE;
                end
            endcase
        end
    end

    // State register. Reset wins over clear_i and any edge, and throws away
    // a partially counted period along with the synchronizer history.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            edge_q      <= 1'b0;
            cnt_q       <= 16'd0;
            period_q    <= 16'd0;
            haveEdge_q  <= 1'b0;
            goodCnt_q   <= 8'd0;
            faultCode_q <= CodeNone;
            state_q     <= ACQUIRE;
        end else begin
            sync1_q     <= clk_div_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            edge_q      <= edgeDet;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            haveEdge_q  <= haveEdge_d;
            goodCnt_q   <= goodCnt_d;
            faultCode_q <= faultCode_d;
            state_q     <= state_d;
        end
    end

    // Status outputs come straight from registered state.
    always_comb begin
        edge_o       = edge_q;
        period_o     = period_q;
        locked_o     = (state_q == LOCKED);
        fault_o      = (state_q == FAULT);
        fault_code_o = faultCode_q;
    end

endmodule

// File: tb/tb_minsoc_clock_monitor.sv
// ---------------------------------------------------------------------------
// tb_minsoc_clock_monitor
//
// Self-checking bench for minsoc_clock_monitor with default parameters
// (DIVISOR 4, TOLERANCE 1, LOCK_COUNT 8, TIMEOUT 16). The divided clock is
// driven on falling edges of clk. Each driven rising edge pushes the expected
// status after that edge onto a scoreboard queue; a monitor pops and
// compares whenever edge_o pulses. Scenario tasks add their own checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_minsoc_clock_monitor;

    logic        clk    = 1'b0;
    logic        rstN   = 1'b0;
    logic        clkDiv = 1'b0;
    logic        clear  = 1'b0;
    logic        edgeOut;
    logic [15:0] periodOut;
    logic        lockedOut;
    logic        faultOut;
    logic [1:0]  faultCodeOut;

    typedef struct {
        logic [15:0] period;
        logic        locked;
        logic        fault;
        logic [1:0]  code;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state (0 acquire, 1 locked, 2 fault)
    int         mPeriod  = 0;
    bit         mHave    = 1'b0;
    int         mGood    = 0;
    int         mState   = 0;
    logic [1:0] mCode    = 2'b00;
    int         lastRise = 0;

    minsoc_clock_monitor #(
        .DIVISOR   (4),
        .TOLERANCE (1),
        .LOCK_COUNT(8),
        .TIMEOUT   (16)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .clk_div_i   (clkDiv),
        .clear_i     (clear),
        .edge_o      (edgeOut),
        .period_o    (periodOut),
        .locked_o    (lockedOut),
        .fault_o     (faultOut),
        .fault_code_o(faultCodeOut)
    );

    // Reference clock: 10 ns period.
    always #5 clk = ~clk;

    // Overall time bound so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard consumer: every edge_o pulse must match the oldest expected
    // entry.
    always @(negedge clk) begin
        if (edgeOut === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_edge: got edge_o=1 expected no edge at cycle %0d", cyc);
            end else begin
                monE = expQ.pop_front();
                if (periodOut !== monE.period) begin
                    errors++;
                    $display("[TB] FAIL edge_period: got %0d expected %0d", periodOut, monE.period);
                end
                checks++;
                if (lockedOut !== monE.locked) begin
                    errors++;
                    $display("[TB] FAIL edge_locked: got %0b expected %0b", lockedOut, monE.locked);
                end
                checks++;
                if (faultOut !== monE.fault) begin
                    errors++;
                    $display("[TB] FAIL edge_fault: got %0b expected %0b", faultOut, monE.fault);
                end
                checks++;
                if (faultCodeOut !== monE.code) begin
                    errors++;
                    $display("[TB] FAIL edge_code: got %0b expected %0b", faultCodeOut, monE.code);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Model update for one rising edge of the divided clock; clearHit marks
    // an edge that coincides with a clear pulse.
    task automatic modelRise(input bit clearHit);
        exp_t e;
        int   p;
        p        = cyc - lastRise;
        lastRise = cyc;
        if (clearHit) begin
            mState = 0;
            mGood  = 0;
            mCode  = 2'b00;
            mHave  = 1'b1;
        end else if (!mHave) begin
            mHave = 1'b1;
        end else begin
            mPeriod = p;
            if (p >= 3 && p <= 5) begin
                if (mState == 0) begin
                    mGood++;
                    if (mGood >= 8) mState = 1;
                end
            end else begin
                if (mState == 0) begin
                    mGood = 0;
                end else if (mState == 1) begin
                    mState = 2;
                    mCode  = 2'b01;
                end
            end
        end
        e.period = 16'(mPeriod);
        e.locked = (mState == 1);
        e.fault  = (mState == 2);
        e.code   = mCode;
        expQ.push_back(e);
    endtask

    task automatic modelClear();
        mState = 0;
        mGood  = 0;
        mCode  = 2'b00;
        mHave  = 1'b0;
    endtask

    task automatic modelReset();
        modelClear();
        mPeriod  = 0;
        lastRise = cyc;
    endtask

    // One divided-clock period of p reference cycles, rising edge first.
    task automatic applyStimulus(input int p);
        clkDiv = 1'b1;
        modelRise(1'b0);
        repeat (p / 2) tick();
        clkDiv = 1'b0;
        repeat (p - p / 2) tick();
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        modelClear();
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) tick();
        checks++;
        if (edgeOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_edge: got %0b expected 0", edgeOut); end
        checks++;
        if (periodOut !== 16'd0) begin errors++; $display("[TB] FAIL reset_period: got %0d expected 0", periodOut); end
        checks++;
        if (lockedOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %0b expected 0", lockedOut); end
        checks++;
        if (faultOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %0b expected 0", faultOut); end
        checks++;
        if (faultCodeOut !== 2'b00) begin errors++; $display("[TB] FAIL reset_code: got %0b expected 00", faultCodeOut); end
        rstN = 1'b1;
        modelReset();
    endtask

    task automatic test_lock();
        repeat (8) applyStimulus(4);
        checks++;
        if (lockedOut !== 1'b0) begin errors++; $display("[TB] FAIL lock_early: got %0b expected 0", lockedOut); end
        applyStimulus(4);
        checks++;
        if (lockedOut !== 1'b1) begin errors++; $display("[TB] FAIL lock_ninth: got %0b expected 1", lockedOut); end
        checks++;
        if (periodOut !== 16'd4) begin errors++; $display("[TB] FAIL lock_period: got %0d expected 4", periodOut); end
        checks++;
        if (faultOut !== 1'b0) begin errors++; $display("[TB] FAIL lock_fault: got %0b expected 0", faultOut); end
    endtask

    task automatic test_bad_period();
        applyStimulus(7);
        applyStimulus(4);
        checks++;
        if (faultOut !== 1'b1) begin errors++; $display("[TB] FAIL bad_fault: got %0b expected 1", faultOut); end
        checks++;
        if (faultCodeOut !== 2'b01) begin errors++; $display("[TB] FAIL bad_code: got %0b expected 01", faultCodeOut); end
        checks++;
        if (lockedOut !== 1'b0) begin errors++; $display("[TB] FAIL bad_locked: got %0b expected 0", lockedOut); end
        checks++;
        if (periodOut !== 16'd7) begin errors++; $display("[TB] FAIL bad_period: got %0d expected 7", periodOut); end
        pulseClear();
        checks++;
        if (faultOut !== 1'b0 || faultCodeOut !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bad_clear: got fault=%0b code=%0b expected fault=0 code=00", faultOut, faultCodeOut);
        end
        repeat (8) applyStimulus(4);
        checks++;
        if (lockedOut !== 1'b0) begin errors++; $display("[TB] FAIL relock_early: got %0b expected 0", lockedOut); end
        applyStimulus(4);
        checks++;
        if (lockedOut !== 1'b1) begin errors++; $display("[TB] FAIL relock: got %0b expected 1", lockedOut); end
    endtask

    task automatic test_stall();
        applyStimulus(4);
        repeat (14) tick();
        checks++;
        if (faultOut !== 1'b0 || lockedOut !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_early: got fault=%0b locked=%0b expected fault=0 locked=1", faultOut, lockedOut);
        end
        tick();
        mState = 2;
        mCode  = 2'b10;
        mHave  = 1'b0;
        checks++;
        if (faultOut !== 1'b1) begin errors++; $display("[TB] FAIL stall_fault: got %0b expected 1", faultOut); end
        checks++;
        if (faultCodeOut !== 2'b10) begin errors++; $display("[TB] FAIL stall_code: got %0b expected 10", faultCodeOut); end
        checks++;
        if (periodOut !== 16'd4) begin errors++; $display("[TB] FAIL stall_period: got %0d expected 4", periodOut); end
        checks++;
        if (lockedOut !== 1'b0) begin errors++; $display("[TB] FAIL stall_locked: got %0b expected 0", lockedOut); end
        repeat (4) applyStimulus(4);
        checks++;
        if (faultOut !== 1'b1 || faultCodeOut !== 2'b10) begin
            errors++;
            $display("[TB] FAIL stall_sticky: got fault=%0b code=%0b expected fault=1 code=10", faultOut, faultCodeOut);
        end
        pulseClear();
        checks++;
        if (faultOut !== 1'b0) begin errors++; $display("[TB] FAIL stall_clear: got %0b expected 0", faultOut); end
    endtask

    task automatic test_tolerance();
        for (int i = 0; i < 9; i++) begin
            applyStimulus((i % 2 == 0) ? 5 : 3);
            if (i == 7) begin
                checks++;
                if (lockedOut !== 1'b0) begin errors++; $display("[TB] FAIL tol_early: got %0b expected 0", lockedOut); end
            end
        end
        checks++;
        if (lockedOut !== 1'b1) begin errors++; $display("[TB] FAIL tol_lock: got %0b expected 1", lockedOut); end
        pulseClear();
        repeat (4) applyStimulus(4);
        applyStimulus(6);
        applyStimulus(4);
        repeat (7) applyStimulus(4);
        checks++;
        if (lockedOut !== 1'b0 || faultOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tol_delay: got locked=%0b fault=%0b expected locked=0 fault=0", lockedOut, faultOut);
        end
        applyStimulus(4);
        checks++;
        if (lockedOut !== 1'b1) begin errors++; $display("[TB] FAIL tol_relock: got %0b expected 1", lockedOut); end
    endtask

    task automatic test_reset_mid();
        clkDiv = 1'b1;
        modelRise(1'b0);
        tick();
        tick();
        clkDiv = 1'b0;
        tick();
        rstN = 1'b0;
        tick();
        checks++;
        if (lockedOut !== 1'b0 || faultOut !== 1'b0 || edgeOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got locked=%0b fault=%0b edge=%0b expected all 0", lockedOut, faultOut, edgeOut);
        end
        checks++;
        if (periodOut !== 16'd0 || faultCodeOut !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midreset_values: got period=%0d code=%0b expected period=0 code=00", periodOut, faultCodeOut);
        end
        rstN = 1'b1;
        modelReset();
        applyStimulus(4);
        checks++;
        if (periodOut !== 16'd0) begin errors++; $display("[TB] FAIL midreset_first: got %0d expected 0", periodOut); end
        applyStimulus(4);
        checks++;
        if (periodOut !== 16'd4) begin errors++; $display("[TB] FAIL midreset_second: got %0d expected 4", periodOut); end
    endtask

    task automatic test_back_to_back();
        repeat (8) applyStimulus(4);
        checks++;
        if (lockedOut !== 1'b1) begin errors++; $display("[TB] FAIL b2b_lock: got %0b expected 1", lockedOut); end
        applyStimulus(7);
        applyStimulus(4);
        checks++;
        if (faultOut !== 1'b1) begin errors++; $display("[TB] FAIL b2b_fault: got %0b expected 1", faultOut); end
        // Edge and clear in the same cycle: the edge condition is high in the
        // cycle that ends on the third rising clk edge after the drive.
        clkDiv = 1'b1;
        modelRise(1'b1);
        tick();
        tick();
        clkDiv = 1'b0;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
        checks++;
        if (faultOut !== 1'b0 || faultCodeOut !== 2'b00 || lockedOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_clear_state: got fault=%0b code=%0b locked=%0b expected 0 00 0", faultOut, faultCodeOut, lockedOut);
        end
        checks++;
        if (periodOut !== 16'd7) begin errors++; $display("[TB] FAIL b2b_clear_period: got %0d expected 7", periodOut); end
        tick();
        applyStimulus(4);
        checks++;
        if (periodOut !== 16'd4) begin errors++; $display("[TB] FAIL b2b_next_period: got %0d expected 4", periodOut); end
    endtask

    initial begin
        $display("[TB] minsoc_clock_monitor bench start");
        tick();
        test_reset();
        test_lock();
        test_bad_period();
        test_stall();
        test_tolerance();
        test_reset_mid();
        test_back_to_back();
        repeat (6) tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_edges: got %0d unseen edges expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
